regfile_param: RTL and testbench
================================

REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 SHALL provide parameter DATA_W, default 16, meaning register width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 2, meaning address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL provide parameter ZERO_R0, default 0, meaning entry 0 is hard-wired to zero when 1.
REQ-004 SHALL provide parameter BYPASS, default 1, meaning write-to-read forwarding is enabled when 1.
REQ-005 SHALL have one clock and a synchronous, active-low reset: clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  synchronous active-low reset, sampled on rising clk.
REQ-007 we  in  1  write request.
REQ-008 waddr  in  ADDR_W  write address.
REQ-009 wdata  in  DATA_W  write data.
REQ-010 wmask  in  DATA_W  per-bit write enable; 1 = bit updated.
REQ-011 raddr_a / raddr_b  in  ADDR_W each  read addresses.
REQ-012 rdata_a / rdata_b  out  DATA_W each  combinational read data.
REQ-013 clr_req  in  1  request to clear all entries.
REQ-014 clr_busy  out  1  high while the clear sequence runs.
REQ-015 clr_done  out  1  single-cycle pulse at clear completion.
REQ-016 wr_rej  out  1  single-cycle pulse: a write was rejected.
REQ-017 dbg_sel  in  ADDR_W  debug entry select; dbg_data  out  DATA_W  raw stored contents of that entry.

Function
REQ-018 Accepted write (we=1, state IDLE) SHALL update entry[waddr] on the rising edge to (old & ~wmask) | (wdata & wmask).
REQ-019 With ZERO_R0=1, writes to address 0 SHALL be discarded without wr_rej; reads and dbg_data of entry 0 SHALL return 0.
REQ-020 Read ports SHALL be fully independent and combinational; both may address the same entry.
REQ-021 With BYPASS=1, when a write is accepted in the current cycle and raddr_x == waddr (and not a discarded zero-register write), rdata_x SHALL equal the merged value of REQ-018; otherwise rdata_x SHALL equal stored contents.
REQ-022 With BYPASS=0, rdata_x SHALL always show stored contents (new value visible the cycle after the write).
REQ-023 dbg_data SHALL never be bypassed.
REQ-024 Clear FSM states: IDLE, CLEAR. IDLE->CLEAR when clr_req=1; idx loads 0.
REQ-025 In CLEAR, one entry per cycle: entry[idx] <= 0, idx increments; after clearing entry DEPTH-1, next state IDLE, clr_done=1 for exactly that one following cycle.
REQ-026 clr_busy SHALL be 1 in every CLEAR cycle (DEPTH cycles total) and 0 in IDLE.
REQ-027 we=1 during CLEAR SHALL be ignored and wr_rej SHALL pulse high that same cycle (combinational on we & busy).
REQ-028 clr_req during CLEAR SHALL be ignored; clr_req held high in the cycle after completion SHALL start a new sequence.
REQ-029 we and clr_req in the same IDLE cycle: write SHALL be accepted that cycle, clear begins next cycle and overwrites it.
REQ-030 idx SHALL wrap only via return to IDLE; no partial clears.

Reset
REQ-031 When rst_n=0 at a rising edge: all entries 0, state IDLE, idx 0, clr_busy 0, clr_done 0; wr_rej 0 while rst_n=0.
REQ-032 Reset mid-CLEAR SHALL abort the sequence without a clr_done pulse.
REQ-033 Reset SHALL have priority over write and clear in the same cycle.

Verification
REQ-034 Reset, then write 0xBEEF to addr 2 mask 0xFFFF -> next cycle rdata_a(raddr 2)=0xBEEF, others 0.
REQ-035 Entry 1=0x1234, write 0xABCD mask 0x00FF -> entry 1=0x12CD; same-cycle rdata_b(raddr 1)=0x12CD with BYPASS=1, 0x1234 with BYPASS=0.
REQ-036 Fill all four entries, pulse clr_req -> clr_busy high 4 cycles, entries zero in order 0..3, clr_done one cycle, then busy low.
REQ-037 we=1 during CLEAR cycle 2 -> wr_rej pulse, target entry ends 0.
REQ-038 ZERO_R0=1: write 0xFFFF to addr 0 -> rdata_a and dbg_data for addr 0 read 0, no wr_rej.
REQ-039 rst_n low at CLEAR cycle 2 -> busy low next cycle, no clr_done, all entries 0.

Source files
------------

// File: rtl/regfile_param.sv
// Parameterised register file: two combinational read ports, one masked write port,
// optional write-to-read forwarding, optional zero register and a sequential clear engine.
module regfile_param #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 2,
    parameter int ZERO_R0 = 0,
    parameter int BYPASS  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] wmask,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              wr_rej,
    input  logic [ADDR_W-1:0] dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              clr_done_q, clr_done_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic              wr_acc;
    logic              wr_zero;
    logic [DATA_W-1:0] merged;

    // A write to entry 0 with the zero register enabled is accepted but has no effect.
    always_comb begin
        wr_zero = (ZERO_R0 != 0) && (waddr == '0);
        wr_acc  = rst_n && we && (state_q == IDLE);
        merged  = (mem_q[waddr] & ~wmask) | (wdata & wmask);
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        clr_done_d = 1'b0;
        mem_d      = mem_q;
        case (state_q)
            IDLE: begin
                if (wr_acc && !wr_zero) begin
                    mem_d[waddr] = merged;
                end
                if (clr_req) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                end
            end
            CLEAR: begin
                mem_d[idx_q] = '0;
                if (idx_q == ADDR_W'(DEPTH - 1)) begin
                    state_d    = IDLE;
                    idx_d      = '0;
                    clr_done_d = 1'b1;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            clr_done_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            clr_done_q <= clr_done_d;
            mem_q      <= mem_d;
        end
    end

    // Forwarding only applies to the read ports; dbg_data always shows stored contents.
    always_comb begin
        rdata_a  = ((ZERO_R0 != 0) && (raddr_a == '0)) ? '0 : mem_q[raddr_a];
        rdata_b  = ((ZERO_R0 != 0) && (raddr_b == '0)) ? '0 : mem_q[raddr_b];
        dbg_data = ((ZERO_R0 != 0) && (dbg_sel == '0)) ? '0 : mem_q[dbg_sel];
        if ((BYPASS != 0) && wr_acc && !wr_zero) begin
            if (raddr_a == waddr) rdata_a = merged;
            if (raddr_b == waddr) rdata_b = merged;
        end
    end

    always_comb begin
        clr_busy = (state_q == CLEAR);
        clr_done = clr_done_q;
        wr_rej   = rst_n && we && (state_q == CLEAR);
    end
endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: two instances (default and ZERO_R0=1/BYPASS=0) driven in lockstep,
// checked by a scoreboard fed from a behavioural model of the register file.
module tb_regfile_param;
  localparam int EXP_W = 51;

  logic clk;
  logic rst_n;
  logic we;
  logic [1:0] waddr;
  logic [15:0] wdata;
  logic [15:0] wmask;
  logic [1:0] raddr_a;
  logic [1:0] raddr_b;
  logic clr_req;
  logic [1:0] dbg_sel;

  logic [15:0] rdata_a0, rdata_b0, dbg_data0;
  logic clr_busy0, clr_done0, wr_rej0;
  logic [15:0] rdata_a1, rdata_b1, dbg_data1;
  logic clr_busy1, clr_done1, wr_rej1;

  regfile_param #(.DATA_W(16), .ADDR_W(2), .ZERO_R0(0), .BYPASS(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .wmask(wmask),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a0), .rdata_b(rdata_b0),
    .clr_req(clr_req), .clr_busy(clr_busy0), .clr_done(clr_done0), .wr_rej(wr_rej0),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data0)
  );

  regfile_param #(.DATA_W(16), .ADDR_W(2), .ZERO_R0(1), .BYPASS(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .wmask(wmask),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a1), .rdata_b(rdata_b1),
    .clr_req(clr_req), .clr_busy(clr_busy1), .clr_done(clr_done1), .wr_rej(wr_rej1),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data1)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [EXP_W-1:0] exp_q0[$];
  logic [EXP_W-1:0] exp_q1[$];
  int chk_cnt = 0;
  int pass_cnt = 0;

  // reference model: instance 0 = plain/forwarding, instance 1 = zero register/no forwarding
  logic [15:0] mem_m [2][4];
  bit clearing_m [2];
  int pos_m [2];
  bit done_m [2];

  function automatic bit zr(input int k);
    return k == 1;
  endfunction

  function automatic bit byp(input int k);
    return k == 0;
  endfunction

  function automatic logic [15:0] stored_m(input int k, input logic [1:0] a);
    if (zr(k) && a == 2'd0) return 16'h0;
    return mem_m[k][a];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) mem_m[k][i] = 16'h0;
      clearing_m[k] = 0;
      pos_m[k] = 0;
      done_m[k] = 0;
    end
  endtask

  // predict this cycle's outputs, push them, then advance model across the clock edge
  task automatic step();
    logic [15:0] mg [2];
    bit acc [2];
    bit disc [2];
    logic [15:0] ra, rb;
    for (int k = 0; k < 2; k++) begin
      acc[k] = rst_n && we && !clearing_m[k];
      disc[k] = zr(k) && waddr == 2'd0;
      mg[k] = (mem_m[k][waddr] & ~wmask) | (wdata & wmask);
      ra = (byp(k) && acc[k] && !disc[k] && raddr_a == waddr) ? mg[k] : stored_m(k, raddr_a);
      rb = (byp(k) && acc[k] && !disc[k] && raddr_b == waddr) ? mg[k] : stored_m(k, raddr_b);
      if (k == 0)
        exp_q0.push_back({ra, rb, stored_m(k, dbg_sel), clearing_m[k], done_m[k],
                          rst_n && we && clearing_m[k]});
      else
        exp_q1.push_back({ra, rb, stored_m(k, dbg_sel), clearing_m[k], done_m[k],
                          rst_n && we && clearing_m[k]});
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        for (int i = 0; i < 4; i++) mem_m[k][i] = 16'h0;
        clearing_m[k] = 0;
        pos_m[k] = 0;
        done_m[k] = 0;
      end else begin
        done_m[k] = 0;
        if (clearing_m[k]) begin
          mem_m[k][pos_m[k]] = 16'h0;
          if (pos_m[k] == 3) begin
            clearing_m[k] = 0;
            done_m[k] = 1;
          end else begin
            pos_m[k]++;
          end
        end else begin
          if (acc[k] && !disc[k]) mem_m[k][waddr] = mg[k];
          if (clr_req) begin
            clearing_m[k] = 1;
            pos_m[k] = 0;
          end
        end
      end
    end
    #1;
  endtask

  task automatic check(input string name, input int k, input logic [15:0] act, input logic [15:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s inst%0d at %0t: got %h expected %h", name, k, $time, act, exp);
  endtask

  task automatic compare(input int k, input logic [EXP_W-1:0] e, input logic [EXP_W-1:0] a);
    check("rdata_a", k, a[50:35], e[50:35]);
    check("rdata_b", k, a[34:19], e[34:19]);
    check("dbg_data", k, a[18:3], e[18:3]);
    check("clr_busy", k, {15'h0, a[2]}, {15'h0, e[2]});
    check("clr_done", k, {15'h0, a[1]}, {15'h0, e[1]});
    check("wr_rej", k, {15'h0, a[0]}, {15'h0, e[0]});
  endtask

  // monitor: outputs are combinational, so every cycle presents one result per instance
  always @(negedge clk) begin
    if (exp_q0.size() > 0)
      compare(0, exp_q0.pop_front(), {rdata_a0, rdata_b0, dbg_data0, clr_busy0, clr_done0, wr_rej0});
    if (exp_q1.size() > 0)
      compare(1, exp_q1.pop_front(), {rdata_a1, rdata_b1, dbg_data1, clr_busy1, clr_done1, wr_rej1});
  end

  task automatic idle_inputs();
    we = 0; waddr = 0; wdata = 0; wmask = 0; clr_req = 0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d, input logic [15:0] m);
    we = 1; waddr = a; wdata = d; wmask = m;
    step();
    we = 0;
  endtask

  task automatic fill_all();
    wr(0, 16'h1111, 16'hFFFF);
    wr(1, 16'h2222, 16'hFFFF);
    wr(2, 16'h3333, 16'hFFFF);
    wr(3, 16'h4444, 16'hFFFF);
  endtask

  // stimulus
  initial begin
    rst_n = 0; idle_inputs(); raddr_a = 0; raddr_b = 0; dbg_sel = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // reset state, wr_rej held low during reset even with we high
    we = 1; waddr = 2; wdata = 16'hFFFF; wmask = 16'hFFFF; raddr_a = 2; raddr_b = 1;
    step();
    rst_n = 1; idle_inputs();

    // basic full write, read next cycle
    raddr_a = 2; raddr_b = 0; dbg_sel = 2;
    wr(2, 16'hBEEF, 16'hFFFF);
    for (int i = 0; i < 4; i++) begin
      raddr_b = 2'(i); dbg_sel = 2'(i);
      step();
    end

    // masked write with same-cycle read on port b
    wr(1, 16'h1234, 16'hFFFF);
    raddr_a = 3; raddr_b = 1;
    wr(1, 16'hABCD, 16'h00FF);
    step();

    // full clear sequence
    fill_all();
    clr_req = 1; step(); clr_req = 0;
    for (int i = 0; i < 6; i++) begin
      dbg_sel = 2'(i % 4); raddr_a = 2'(i % 4);
      step();
    end

    // write during clear is rejected
    fill_all();
    clr_req = 1; step(); clr_req = 0;
    step();
    raddr_a = 3; dbg_sel = 3;
    wr(3, 16'h5A5A, 16'hFFFF);
    repeat (4) step();

    // zero register write
    raddr_a = 0; dbg_sel = 0;
    wr(0, 16'hFFFF, 16'hFFFF);
    step();

    // reset mid-clear
    fill_all();
    clr_req = 1; step(); clr_req = 0;
    step();
    rst_n = 0; step(); rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i); raddr_b = 2'(i);
      step();
    end

    // write and clear request together; clr_req held for back-to-back sequences
    fill_all();
    we = 1; waddr = 2; wdata = 16'h7777; wmask = 16'hFFFF; clr_req = 1; raddr_a = 2;
    step();
    we = 0;
    repeat (10) step();
    clr_req = 0;
    repeat (2) step();

    // randomized traffic
    for (int n = 0; n < 500; n++) begin
      rst_n = ($urandom_range(0, 39) != 0);
      we = $urandom_range(0, 1);
      waddr = 2'($urandom_range(0, 3));
      wdata = 16'($urandom);
      wmask = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      raddr_a = ($urandom_range(0, 2) == 0) ? waddr : 2'($urandom_range(0, 3));
      raddr_b = ($urandom_range(0, 2) == 0) ? waddr : 2'($urandom_range(0, 3));
      dbg_sel = 2'($urandom_range(0, 3));
      clr_req = ($urandom_range(0, 11) == 0);
      step();
    end

    rst_n = 1; idle_inputs();
    @(negedge clk);
    #1;
    chk_cnt++;
    if (exp_q0.size() == 0 && exp_q1.size() == 0) pass_cnt++;
    else $display("FAIL drain: got %0d/%0d pending expected 0/0", exp_q0.size(), exp_q1.size());
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
